// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches 16-bit and 32-bit instructions from a
// halfword-addressed instruction memory. Each instruction is issued to the
// consumer with a valid/ready handshake. The consumer can redirect the fetch
// stream at any time with pc_load.
// Optional feature: define INSTR_FETCH_UNKNOWN_TRAP_EN to trap halfwords that
// match no instruction group. A trapped halfword raises bad_instr_out and
// parks the sequencer in HALT until the next redirect or reset.
module instr_fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_load,
  input  logic [15:0] pc_load_addr,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_hi_out,
  output logic [15:0] instr_lo_out,
  output logic        instr_is_long_out,
  output logic [15:0] instr_pc_out
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
  ,
  output logic        bad_instr_out
`endif
);

`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
  typedef enum logic [1:0] {FETCH_HI, FETCH_LO, ISSUE, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH_HI, FETCH_LO, ISSUE} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_hi_q, instr_hi_d;
  logic [15:0] instr_lo_q, instr_lo_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        is_long_q, is_long_d;
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
  logic        bad_q, bad_d;
`endif

  // Group 5 (top six bits 111000) marks the first half of a 32-bit instruction.
  function automatic logic is_long_hw(input logic [15:0] hw);
    return hw[15:10] == 6'b111000;
  endfunction

`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
  // These encodings are not assigned to any instruction group.
  function automatic logic is_unknown_hw(input logic [15:0] hw);
    return (hw[15:10] == 6'b111001) || (hw[15:10] == 6'b111010) ||
           (hw[15:10] == 6'b111011) || (hw[15:12] == 4'b1111);
  endfunction
`endif

  // Next-state and capture logic. A redirect beats everything else, so data
  // returned in the same cycle as a redirect is dropped.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_hi_d = instr_hi_q;
    instr_lo_d = instr_lo_q;
    instr_pc_d = instr_pc_q;
    is_long_d  = is_long_q;
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
    bad_d      = bad_q;
`endif
    if (pc_load) begin
      pc_d    = pc_load_addr;
      state_d = FETCH_HI;
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
      bad_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH_HI: begin
          if (mem_ack) begin
            instr_hi_d = mem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 16'd1;
            if (is_long_hw(mem_rdata)) begin
              is_long_d = 1'b1;
              state_d   = FETCH_LO;
            end else begin
              is_long_d  = 1'b0;
              instr_lo_d = 16'h0000;
              state_d    = ISSUE;
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
              if (is_unknown_hw(mem_rdata)) begin
                bad_d   = 1'b1;
                state_d = HALT;
              end
`endif
            end
          end
        end
        FETCH_LO: begin
          if (mem_ack) begin
            instr_lo_d = mem_rdata;
            pc_d       = pc_q + 16'd1;
            state_d    = ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) state_d = FETCH_HI;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State register; reset overrides redirect, ack and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_HI;
      pc_q       <= 16'h0000;
      instr_hi_q <= 16'h0000;
      instr_lo_q <= 16'h0000;
      instr_pc_q <= 16'h0000;
      is_long_q  <= 1'b0;
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
      bad_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_hi_q <= instr_hi_d;
      instr_lo_q <= instr_lo_d;
      instr_pc_q <= instr_pc_d;
      is_long_q  <= is_long_d;
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
      bad_q      <= bad_d;
`endif
    end
  end

  // Outputs are decoded from the registered state, so they are glitch-free
  // and hold steady while an issued instruction waits for acceptance.
  always_comb begin
    mem_req           = (state_q == FETCH_HI) || (state_q == FETCH_LO);
    mem_addr          = pc_q;
    instr_valid       = (state_q == ISSUE);
    instr_hi_out      = instr_hi_q;
    instr_lo_out      = instr_lo_q;
    instr_is_long_out = is_long_q;
    instr_pc_out      = instr_pc_q;
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
    bad_instr_out     = bad_q;
`endif
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed testbench for instr_fetch_sequencer. It covers both build options,
// with and without INSTR_FETCH_UNKNOWN_TRAP_EN.
module tb_instr_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_hi_out;
  logic [15:0] instr_lo_out;
  logic        instr_is_long_out;
  logic [15:0] instr_pc_out;
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
  logic        bad_instr_out;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  instr_fetch_sequencer dut (
    .clk(clk), .rst(rst), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_hi_out(instr_hi_out), .instr_lo_out(instr_lo_out),
    .instr_is_long_out(instr_is_long_out), .instr_pc_out(instr_pc_out)
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
    , .bad_instr_out(bad_instr_out)
`endif
  );

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_load = 1'b0; pc_load_addr = 16'h0000; mem_ack = 1'b0; instr_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_load = 1'b1; pc_load_addr = 16'h5555; mem_ack = 1'b1; instr_ready = 1'b1;
    step(); step();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", mem_addr); end
    total++; if (instr_hi_out !== 16'h0000 || instr_lo_out !== 16'h0000 || instr_pc_out !== 16'h0000)
      begin bad++; $display("FAIL reset_instr got=%h/%h/%h exp=0000/0000/0000", instr_hi_out, instr_lo_out, instr_pc_out); end
    total++; if (instr_is_long_out !== 1'b0) begin bad++; $display("FAIL reset_long got=%b exp=0", instr_is_long_out); end
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
    total++; if (bad_instr_out !== 1'b0) begin bad++; $display("FAIL reset_bad got=%b exp=0", bad_instr_out); end
`endif
  endtask

  task automatic test_basic_issue();
    do_reset();
    mem_ack = 1'b1; instr_ready = 1'b1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0)
      begin bad++; $display("FAIL basic_first_req got=%b/%h/%b exp=1/0000/0", mem_req, mem_addr, instr_valid); end
    step();
    total++; if (instr_valid !== 1'b1 || instr_hi_out !== 16'h1234 || instr_is_long_out !== 1'b0 ||
                 instr_pc_out !== 16'h0000 || instr_lo_out !== 16'h0000 || mem_req !== 1'b0)
      begin bad++; $display("FAIL basic_issue got=%b/%h/%b/%h/%h/%b exp=1/1234/0/0000/0000/0", instr_valid,
        instr_hi_out, instr_is_long_out, instr_pc_out, instr_lo_out, mem_req); end
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || instr_valid !== 1'b0)
      begin bad++; $display("FAIL basic_next got=%b/%h/%b exp=1/0001/0", mem_req, mem_addr, instr_valid); end
    step();
    total++; if (instr_valid !== 1'b1 || instr_hi_out !== 16'h0001 || instr_pc_out !== 16'h0001)
      begin bad++; $display("FAIL basic_back_to_back got=%b/%h/%h exp=1/0001/0001", instr_valid, instr_hi_out, instr_pc_out); end
  endtask

  task automatic test_long_and_stall();
    pc_load = 1'b1; pc_load_addr = 16'h0004; mem_ack = 1'b1; instr_ready = 1'b0;
    step();
    pc_load = 1'b0;
    total++; if (mem_addr !== 16'h0004 || mem_req !== 1'b1 || instr_valid !== 1'b0)
      begin bad++; $display("FAIL long_hi_addr got=%h/%b/%b exp=0004/1/0", mem_addr, mem_req, instr_valid); end
    step();
    total++; if (mem_addr !== 16'h0005 || mem_req !== 1'b1 || instr_valid !== 1'b0)
      begin bad++; $display("FAIL long_lo_addr got=%h/%b/%b exp=0005/1/0", mem_addr, mem_req, instr_valid); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instr_hi_out !== 16'hE0A5 ||
                   instr_lo_out !== 16'h7F01 || instr_is_long_out !== 1'b1 || instr_pc_out !== 16'h0004)
        begin bad++; $display("FAIL long_stall[%0d] got=%b/%b/%h/%h/%b/%h exp=1/0/e0a5/7f01/1/0004", i,
          instr_valid, mem_req, instr_hi_out, instr_lo_out, instr_is_long_out, instr_pc_out); end
    end
    instr_ready = 1'b1;
    step();
    total++; if (mem_addr !== 16'h0006 || mem_req !== 1'b1 || instr_valid !== 1'b0)
      begin bad++; $display("FAIL long_next got=%h/%b/%b exp=0006/1/0", mem_addr, mem_req, instr_valid); end
  endtask

  task automatic test_wait_states();
    pc_load = 1'b1; pc_load_addr = 16'h0004; mem_ack = 1'b0; instr_ready = 1'b0;
    step();
    pc_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (mem_addr !== 16'h0004 || mem_req !== 1'b1 || instr_valid !== 1'b0)
        begin bad++; $display("FAIL wait_hi[%0d] got=%h/%b/%b exp=0004/1/0", i, mem_addr, mem_req, instr_valid); end
    end
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (mem_addr !== 16'h0005 || mem_req !== 1'b1 || instr_valid !== 1'b0)
        begin bad++; $display("FAIL wait_lo[%0d] got=%h/%b/%b exp=0005/1/0", i, mem_addr, mem_req, instr_valid); end
    end
    mem_ack = 1'b1; step();
    total++; if (instr_valid !== 1'b1 || instr_lo_out !== 16'h7F01 || instr_hi_out !== 16'hE0A5)
      begin bad++; $display("FAIL wait_issue got=%b/%h/%h exp=1/e0a5/7f01", instr_valid, instr_hi_out, instr_lo_out); end
  endtask

  task automatic test_load_in_lo();
    pc_load = 1'b1; pc_load_addr = 16'h0004; mem_ack = 1'b1; instr_ready = 1'b0;
    step();
    pc_load = 1'b0;
    step();
    pc_load = 1'b1; pc_load_addr = 16'h0100;
    step();
    pc_load = 1'b0; mem_ack = 1'b0;
    total++; if (mem_addr !== 16'h0100 || mem_req !== 1'b1 || instr_valid !== 1'b0)
      begin bad++; $display("FAIL load_lo_addr got=%h/%b/%b exp=0100/1/0", mem_addr, mem_req, instr_valid); end
    step();
    total++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0100)
      begin bad++; $display("FAIL load_lo_noissue got=%b/%h exp=0/0100", instr_valid, mem_addr); end
  endtask

  task automatic test_load_with_ack();
    pc_load = 1'b1; pc_load_addr = 16'h0300; mem_ack = 1'b1; instr_ready = 1'b0;
    step();
    pc_load_addr = 16'h0310;
    step();
    pc_load = 1'b0;
    total++; if (mem_addr !== 16'h0310 || instr_valid !== 1'b0)
      begin bad++; $display("FAIL load_ack_drop got=%h/%b exp=0310/0", mem_addr, instr_valid); end
    step();
    total++; if (instr_valid !== 1'b1 || instr_hi_out !== 16'h0310 || instr_pc_out !== 16'h0310)
      begin bad++; $display("FAIL load_ack_issue got=%b/%h/%h exp=1/0310/0310", instr_valid, instr_hi_out, instr_pc_out); end
    pc_load = 1'b1; pc_load_addr = 16'h0200; instr_ready = 1'b1;
    step();
    pc_load = 1'b0; instr_ready = 1'b0;
    total++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0200 || mem_req !== 1'b1)
      begin bad++; $display("FAIL load_issue got=%b/%h/%b exp=0/0200/1", instr_valid, mem_addr, mem_req); end
  endtask

  task automatic test_wrap();
    pc_load = 1'b1; pc_load_addr = 16'hFFFF; mem_ack = 1'b1; instr_ready = 1'b0;
    step();
    pc_load = 1'b0;
    total++; if (mem_addr !== 16'hFFFF) begin bad++; $display("FAIL wrap_hi got=%h exp=ffff", mem_addr); end
    step();
    total++; if (mem_addr !== 16'h0000 || mem_req !== 1'b1)
      begin bad++; $display("FAIL wrap_lo got=%h/%b exp=0000/1", mem_addr, mem_req); end
    step();
    total++; if (instr_valid !== 1'b1 || instr_hi_out !== 16'hE000 || instr_lo_out !== 16'h1234 ||
                 instr_is_long_out !== 1'b1 || instr_pc_out !== 16'hFFFF)
      begin bad++; $display("FAIL wrap_issue got=%b/%h/%h/%b/%h exp=1/e000/1234/1/ffff", instr_valid,
        instr_hi_out, instr_lo_out, instr_is_long_out, instr_pc_out); end
    instr_ready = 1'b1;
    step();
    total++; if (mem_addr !== 16'h0001 || mem_req !== 1'b1)
      begin bad++; $display("FAIL wrap_next got=%h/%b exp=0001/1", mem_addr, mem_req); end
  endtask

  task automatic test_reset_mid_long();
    pc_load = 1'b1; pc_load_addr = 16'h0004; mem_ack = 1'b1; instr_ready = 1'b0;
    step();
    pc_load = 1'b0;
    step();
    rst = 1'b1; pc_load = 1'b1; pc_load_addr = 16'h0200; instr_ready = 1'b1;
    step();
    total++; if (mem_addr !== 16'h0000 || instr_valid !== 1'b0 || instr_hi_out !== 16'h0000 || instr_is_long_out !== 1'b0)
      begin bad++; $display("FAIL rst_mid got=%h/%b/%h/%b exp=0000/0/0000/0", mem_addr, instr_valid, instr_hi_out, instr_is_long_out); end
    rst = 1'b0; pc_load = 1'b0; mem_ack = 1'b0;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0)
      begin bad++; $display("FAIL rst_mid_after got=%b/%h/%b exp=1/0000/0", mem_req, mem_addr, instr_valid); end
  endtask

  task automatic test_unknown_group();
    pc_load = 1'b1; pc_load_addr = 16'h0040; mem_ack = 1'b1; instr_ready = 1'b0;
    step();
    pc_load = 1'b0;
    step();
`ifdef INSTR_FETCH_UNKNOWN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      total++; if (bad_instr_out !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0)
        begin bad++; $display("FAIL trap_halt[%0d] got=%b/%b/%b exp=1/0/0", i, bad_instr_out, instr_valid, mem_req); end
      step();
    end
    pc_load = 1'b1; pc_load_addr = 16'h0004;
    step();
    pc_load = 1'b0;
    total++; if (bad_instr_out !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0004)
      begin bad++; $display("FAIL trap_exit got=%b/%b/%h exp=0/1/0004", bad_instr_out, mem_req, mem_addr); end
`else
    total++; if (instr_valid !== 1'b1 || instr_hi_out !== 16'hF000 || instr_is_long_out !== 1'b0 || instr_lo_out !== 16'h0000)
      begin bad++; $display("FAIL unknown_issue got=%b/%h/%b/%h exp=1/f000/0/0000", instr_valid, instr_hi_out,
        instr_is_long_out, instr_lo_out); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {4'h0, i[11:0]};
    mem[16'h0000] = 16'h1234;
    mem[16'h0004] = 16'hE0A5;
    mem[16'h0005] = 16'h7F01;
    mem[16'h0040] = 16'hF000;
    mem[16'hFFFF] = 16'hE000;
    rst = 1'b1; pc_load = 1'b0; pc_load_addr = 16'h0000; mem_ack = 1'b0; instr_ready = 1'b0;
    test_reset();
    test_basic_issue();
    test_long_and_stall();
    test_wait_states();
    test_load_in_lo();
    test_load_with_ack();
    test_wrap();
    test_reset_mid_long();
    test_unknown_group();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
